// File: rtl/rom_burst_reader.sv
// Burst read sequencer for a block-ROM port: issues LEN reads from BASE and streams them out.
// Optional read-check flag rd_err is built in when ROM_RD_CHECK_EN is defined.
module rom_burst_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 9,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_din,
  input  logic [DATA_W-1:0] rom_dout,
  input  logic              rom_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef ROM_RD_CHECK_EN
  ,
  output logic              rd_err
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CRD_W = $clog2(DEPTH + RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic [RD_LAT-1:0] pipe;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CRD_W-1:0]  inflight;
  logic [CRD_W-1:0]  credit_used;
  logic              accept;
  logic              push;
  logic              pop;
  logic              last_issue;

  assign accept     = (state == IDLE) && start;
  assign push       = pipe[RD_LAT-1];
  assign pop        = m_valid && m_ready;
  assign last_issue = rom_en && (issued == len_q - 1'b1);

  // Reads still in the BRAM pipe plus buffered words must never exceed FIFO room.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CRD_W'(pipe[i]);
    end
  end

  assign credit_used = inflight + CRD_W'(count);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (len == '0) ? FIN : RUN;
      RUN:     if (last_issue) state_next = DRAIN;
      DRAIN:   if ((pipe == '0) && ((count == '0) || ((count == CNT_W'(1)) && pop)))
                 state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    done   = (state == FIN);
    rom_en = (state == RUN) && (credit_used < CRD_W'(DEPTH));
  end

  assign rom_we   = 1'b0;
  assign rom_din  = '0;
  assign rom_addr = base_q + issued[ADDR_W-1:0];
  assign m_data   = mem[rd_ptr];
  assign m_valid  = (count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      issued <= '0;
      pipe   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        base_q <= base_addr;
        len_q  <= len;
        issued <= '0;
      end else if (rom_en) begin
        issued <= issued + 1'b1;
      end
      pipe[0] <= rom_en;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rom_dout;
  end

`ifdef ROM_RD_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_err <= 1'b0;
    end else if (accept) begin
      rd_err <= 1'b0;
    end else if (push && !rom_valid) begin
      rd_err <= 1'b1;
    end
  end
`else
  logic unused_rom_valid;
  assign unused_rom_valid = rom_valid;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: table-driven bursts, random bursts and reset/rd_err sequences,
// all checked against an arithmetic model of the ROM contents (mem[i] = 16'hA000 + i).
module tb_rom_burst_reader;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  len = '0;
  logic        busy, done, rom_en, rom_we;
  logic [7:0]  rom_addr;
  logic [15:0] rom_din;
  logic [15:0] rom_dout = '0;
  logic        rom_valid;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
`ifdef ROM_RD_CHECK_EN
  logic        rd_err;
`endif

  logic romSeen = 1'b0;
  logic killValid = 1'b0;
  int   nVectors = 0;
  int   nMiscompares = 0;

  typedef struct {
    logic [7:0] base;
    logic [8:0] len;
    int         readyMode;
    bit         timing;
    bit         restart;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  // ROM model with one cycle of read latency and a sticky valid flag.
  always @(posedge clk) begin
    if (rom_en) begin
      rom_dout <= 16'hA000 + {8'h00, rom_addr};
      romSeen  <= 1'b1;
    end
  end
  assign rom_valid = romSeen & ~killValid;

  rom_burst_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rom_en    (rom_en),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_din   (rom_din),
    .rom_dout  (rom_dout),
    .rom_valid (rom_valid),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
`ifdef ROM_RD_CHECK_EN
    ,
    .rd_err    (rd_err)
`endif
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic [8:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
  endtask

  // readyMode: 0 = always ready, 1 = random ready, 2 = stalled for the first 10 cycles.
  task automatic runBurst(input logic [7:0] b, input logic [8:0] l, input int readyMode,
                          input bit timing, input bit restart);
    logic [15:0] expq [$];
    logic [7:0]  a;
    int issued = 0;
    int got = 0;
    int firstValid = -1;
    int doneCycle = -1;
    int maxOut = 0;
    int budget;
    for (int i = 0; i < int'(l); i++) begin
      a = b + 8'(i);
      expq.push_back(16'hA000 + {8'h00, a});
    end
    budget = 4 * int'(l) + 60;
    @(negedge clk);
    applyStimulus(b, l);
    m_ready = (readyMode == 0);
    for (int k = 1; (k <= budget) && (doneCycle < 0); k++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart && k == 2) applyStimulus(b + 8'h55, 9'd3);
      case (readyMode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (k > 10);
      endcase
      if (readyMode == 2 && k == 10) begin
        checkOutput("stallNoIssue", {31'd0, rom_en}, 32'd0);
        checkOutput("stallIssued", issued, DEPTH);
      end
      if (rom_en) begin
        a = b + 8'(issued);
        checkOutput("romAddr", {24'd0, rom_addr}, {24'd0, a});
        issued++;
      end
      if (m_valid && firstValid < 0) firstValid = k;
      if (m_valid && !m_ready && got < int'(l))
        checkOutput("headData", {16'd0, m_data}, {16'd0, expq[got]});
      if (m_valid && m_ready) begin
        if (got < int'(l)) checkOutput("mData", {16'd0, m_data}, {16'd0, expq[got]});
        got++;
      end
      if (issued - got > maxOut) maxOut = issued - got;
      if (done) begin
        doneCycle = k;
        checkOutput("busyAtDone", {31'd0, busy}, 32'd1);
      end
    end
    checkOutput("doneSeen", {31'd0, doneCycle >= 0}, 32'd1);
    checkOutput("wordCount", got, {23'd0, l});
    checkOutput("issueCount", issued, {23'd0, l});
    checkOutput("maxOutstanding", {31'd0, maxOut <= DEPTH}, 32'd1);
    if (timing) begin
      checkOutput("doneCycle", doneCycle, (l == 0) ? 1 : int'(l) + 3);
      if (l != 0) checkOutput("firstValid", firstValid, 3);
    end
    @(negedge clk);
    checkOutput("idleBusy", {31'd0, busy}, 32'd0);
    checkOutput("idleDone", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int got;
    int doneSeen;
    vecs[0] = '{8'h10, 9'd4,   0, 1'b1, 1'b0};
    vecs[1] = '{8'hFE, 9'd4,   0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 9'd0,   0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 9'd16,  2, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 9'd256, 0, 1'b1, 1'b0};
    vecs[5] = '{8'h40, 9'd4,   0, 1'b1, 1'b1};
    vecs[6] = '{8'h33, 9'd7,   1, 1'b0, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy",   {31'd0, busy},    32'd0);
    checkOutput("rstDone",   {31'd0, done},    32'd0);
    checkOutput("rstRomEn",  {31'd0, rom_en},  32'd0);
    checkOutput("rstValid",  {31'd0, m_valid}, 32'd0);
    checkOutput("rstAddr",   {24'd0, rom_addr}, 32'd0);
    checkOutput("romWe",     {31'd0, rom_we},  32'd0);
    checkOutput("romDin",    {16'd0, rom_din}, 32'd0);
`ifdef ROM_RD_CHECK_EN
    checkOutput("rstRdErr",  {31'd0, rd_err},  32'd0);
`endif
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      runBurst(vecs[v].base, vecs[v].len, vecs[v].readyMode, vecs[v].timing, vecs[v].restart);
    end

    for (int r = 0; r < 15; r++) begin
      runBurst(8'($urandom), 9'($urandom_range(0, 40)), 1, 1'b0, 1'b0);
    end

    // Reset in the middle of a burst, then a fresh burst must start cleanly.
    @(negedge clk);
    applyStimulus(8'h00, 9'd8);
    m_ready = 1'b1;
    got = 0;
    for (int k = 1; k <= 40 && got < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_valid && m_ready) got++;
    end
    checkOutput("rstGot", got, 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midRstValid", {31'd0, m_valid}, 32'd0);
    checkOutput("midRstBusy",  {31'd0, busy},    32'd0);
    checkOutput("midRstRomEn", {31'd0, rom_en},  32'd0);
    runBurst(8'h20, 9'd4, 0, 1'b1, 1'b0);

`ifdef ROM_RD_CHECK_EN
    killValid = 1'b1;
    runBurst(8'h05, 9'd2, 0, 1'b1, 1'b0);
    checkOutput("rdErrSet", {31'd0, rd_err}, 32'd1);
    killValid = 1'b0;
    @(negedge clk);
    applyStimulus(8'h06, 9'd1);
    @(negedge clk);
    start = 1'b0;
    checkOutput("rdErrClr", {31'd0, rd_err}, 32'd0);
    doneSeen = 0;
    for (int k = 0; k < 30 && doneSeen == 0; k++) begin
      @(negedge clk);
      if (done) doneSeen = 1;
    end
    checkOutput("rdErrDone", doneSeen, 1);
    checkOutput("rdErrStay", {31'd0, rd_err}, 32'd0);
`else
    doneSeen = 0;
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
